// File: rtl/split_seq_checker.sv
// Streaming split-constraint checker: range-checks one variable per beat against a
// per-index table and reports the ANDed frame verdict plus failure diagnostics.
module split_seq_checker #(
    parameter int unsigned NUM_VARS = 150,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned IDX_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we_i,
    input  logic [IDX_W-1:0]  cfg_idx_i,
    input  logic              cfg_en_i,
    input  logic [DATA_W-1:0] cfg_lo_i,
    input  logic [DATA_W-1:0] cfg_hi_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_last_i,
    output logic              busy_o,
    output logic              x_valid_o,
    output logic              x_o,
    output logic [IDX_W-1:0]  fail_idx_o,
    output logic [IDX_W-1:0]  fail_cnt_o,
    output logic              len_err_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e state_q, state_d;

    logic [NUM_VARS-1:0] en_q;
    logic [DATA_W-1:0]   lo_q [NUM_VARS];
    logic [DATA_W-1:0]   hi_q [NUM_VARS];

    logic             start_pend_q, start_pend_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] fail_idx_q, fail_idx_d;
    logic [IDX_W-1:0] fail_cnt_q, fail_cnt_d;
    logic             acc_q, acc_d;
    logic             len_err_q, len_err_d;
    logic             x_q, x_d;

    logic go, beat, at_end, final_beat, pass, cfg_ok;

    assign go         = (state_q == StIdle) && (start_i || start_pend_q);
    assign beat       = (state_q == StRun) && in_valid_i;
    assign at_end     = (cnt_q == IDX_W'(NUM_VARS - 1));
    assign final_beat = beat && (in_last_i || at_end);
    assign pass       = !en_q[cnt_q] || (lo_q[cnt_q] <= in_data_i && in_data_i <= hi_q[cnt_q]);
    assign cfg_ok     = (state_q == StIdle) && cfg_we_i && (32'(cfg_idx_i) < NUM_VARS);

    // A start seen during DONE is held one cycle and consumed in IDLE.
    assign start_pend_d = (state_q == StDone) && start_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (go) state_d = StRun;
            StRun:   if (final_beat) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready_o = (state_q == StRun);
        busy_o     = (state_q != StIdle);
        x_valid_o  = (state_q == StDone);
    end

    always_comb begin
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        fail_idx_d = fail_idx_q;
        fail_cnt_d = fail_cnt_q;
        len_err_d  = len_err_q;
        x_d        = x_q;
        if (go) begin
            cnt_d      = '0;
            acc_d      = 1'b1;
            fail_idx_d = '0;
            fail_cnt_d = '0;
            len_err_d  = 1'b0;
        end
        if (beat) begin
            cnt_d = final_beat ? '0 : cnt_q + 1'b1;
            if (!pass) begin
                acc_d = 1'b0;
                if (acc_q) fail_idx_d = cnt_q;
                if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + 1'b1;
            end
            if (final_beat) begin
                len_err_d = (in_last_i != at_end);
                x_d       = acc_d && !len_err_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_pend_q <= 1'b0;
            cnt_q        <= '0;
            acc_q        <= 1'b1;
            fail_idx_q   <= '0;
            fail_cnt_q   <= '0;
            len_err_q    <= 1'b0;
            x_q          <= 1'b1;
        end else begin
            start_pend_q <= start_pend_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            fail_idx_q   <= fail_idx_d;
            fail_cnt_q   <= fail_cnt_d;
            len_err_q    <= len_err_d;
            x_q          <= x_d;
        end
    end

    // Cleared table means every entry passes, so an unconfigured block yields x=1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q <= '0;
            for (int unsigned i = 0; i < NUM_VARS; i++) begin
                lo_q[i] <= '0;
                hi_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_VARS; i++) begin
                if (cfg_ok && cfg_idx_i == IDX_W'(i)) begin
                    en_q[i] <= cfg_en_i;
                    lo_q[i] <= cfg_lo_i;
                    hi_q[i] <= cfg_hi_i;
                end
            end
        end
    end

    assign x_o        = x_q;
    assign fail_idx_o = fail_idx_q;
    assign fail_cnt_o = fail_cnt_q;
    assign len_err_o  = len_err_q;

endmodule

// File: tb/tb_split_seq_checker.sv
// Bench for split_seq_checker: frame-level reference model plus per-cycle output compare.
module tb_split_seq_checker;

    localparam int unsigned NV = 150;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we, cfg_en, start, in_valid, in_last;
    logic [7:0]  cfg_idx;
    logic [15:0] cfg_lo, cfg_hi, in_data;
    logic        in_ready, busy, x_valid, x, len_err;
    logic [7:0]  fail_idx, fail_cnt;

    always #5 clk = ~clk;

    split_seq_checker #(.NUM_VARS(NV), .DATA_W(16), .IDX_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we_i   (cfg_we),
        .cfg_idx_i  (cfg_idx),
        .cfg_en_i   (cfg_en),
        .cfg_lo_i   (cfg_lo),
        .cfg_hi_i   (cfg_hi),
        .start_i    (start),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .in_last_i  (in_last),
        .busy_o     (busy),
        .x_valid_o  (x_valid),
        .x_o        (x),
        .fail_idx_o (fail_idx),
        .fail_cnt_o (fail_cnt),
        .len_err_o  (len_err)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Expected outputs for the current cycle, maintained by the driver.
    logic       e_ready = 0, e_busy = 0, e_xv = 0, e_x = 1, e_lerr = 0;
    logic [7:0] e_fidx = 0, e_fcnt = 0;
    logic       chk_on = 0;

    // Reference table and frame contents.
    logic        m_en [NV];
    logic [15:0] m_lo [NV];
    logic [15:0] m_hi [NV];
    logic [15:0] bd   [NV];
    logic        bl   [NV];

    logic       r_x, r_lerr;
    logic [7:0] r_fidx, r_fcnt;

    always @(negedge clk) begin
        if (chk_on) begin
            chk("in_ready", 32'(in_ready), 32'(e_ready));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("x_valid", 32'(x_valid), 32'(e_xv));
            if (!e_busy || e_xv) begin
                chk("x", 32'(x), 32'(e_x));
                chk("fail_idx", 32'(fail_idx), 32'(e_fidx));
                chk("fail_cnt", 32'(fail_cnt), 32'(e_fcnt));
                chk("len_err", 32'(len_err), 32'(e_lerr));
            end
        end
    end

    task automatic clear_model();
        for (int k = 0; k < NV; k++) begin
            m_en[k] = 0;
            m_lo[k] = 0;
            m_hi[k] = 0;
        end
    endtask

    task automatic fill(input logic [15:0] val, input int lastpos);
        for (int k = 0; k < NV; k++) begin
            bd[k] = val;
            bl[k] = (k == lastpos);
        end
    endtask

    // Frame verdict from the whole frame, ending at index f.
    task automatic model_done(input int f);
        int nf = 0;
        int first = 0;
        for (int k = 0; k <= f; k++) begin
            if (m_en[k] && !(m_lo[k] <= bd[k] && bd[k] <= m_hi[k])) begin
                if (nf == 0) first = k;
                nf++;
            end
        end
        e_lerr = !(bl[f] && f == NV - 1);
        e_x    = (nf == 0) && !e_lerr;
        e_fidx = 8'(first);
        e_fcnt = (nf > 255) ? 8'd255 : 8'(nf);
    endtask

    task automatic cfg_write(input int idx, input logic en, input logic [15:0] lo,
                             input logic [15:0] hi);
        cfg_we = 1; cfg_idx = 8'(idx); cfg_en = en; cfg_lo = lo; cfg_hi = hi;
        @(posedge clk); #1;
        cfg_we = 0;
        if (idx < NV) begin
            m_en[idx] = en;
            m_lo[idx] = lo;
            m_hi[idx] = hi;
        end
    endtask

    task automatic do_reset();
        rst_n = 0; in_valid = 0; start = 0; cfg_we = 0;
        e_ready = 0; e_busy = 0; e_xv = 0; e_x = 1; e_fidx = 0; e_fcnt = 0; e_lerr = 0;
        clear_model();
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_x_valid", 32'(x_valid), 32'd0);
        chk("rst_x", 32'(x), 32'd1);
        chk("rst_fail_cnt", 32'(fail_cnt), 32'd0);
        chk("rst_fail_idx", 32'(fail_idx), 32'd0);
        chk("rst_len_err", 32'(len_err), 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    // Entry and exit: 1 time unit after a rising edge, DUT in IDLE.
    task automatic run_frame(input int gap_pct, input bit pre_started, input bit start_in_done,
                             input bit cfg_at_start, input bit cfg_in_run, input int abort_at);
        int  i = 0;
        int  cyc = 0;
        bit  v;
        if (!pre_started) begin
            start = 1;
            if (cfg_at_start) begin
                cfg_we = 1; cfg_idx = 8'd7; cfg_en = 1; cfg_lo = 16'd0; cfg_hi = 16'd5;
            end
        end
        @(posedge clk); #1;
        start = 0; cfg_we = 0;
        if (cfg_at_start) begin
            m_en[7] = 1; m_lo[7] = 0; m_hi[7] = 5;
        end
        e_ready = 1; e_busy = 1; e_xv = 0;
        forever begin
            if (abort_at >= 0 && i == abort_at) begin
                do_reset();
                return;
            end
            v        = ($urandom_range(99) >= gap_pct);
            in_valid = v;
            in_data  = v ? bd[i] : 16'($urandom);
            in_last  = v ? bl[i] : 1'($urandom);
            if (cfg_in_run && cyc == 0) begin
                cfg_we = 1; cfg_idx = 8'd3; cfg_en = 1; cfg_lo = 16'd100; cfg_hi = 16'd200;
                start = 1;
            end
            @(posedge clk); #1;
            cfg_we = 0; start = 0; cyc++;
            if (v) begin
                if (bl[i] || i == NV - 1) break;
                i++;
            end
            if (cyc > 4000) begin
                n_tot++;
                $display("FAIL frame_bound: got %0d cycles required at most 4000", cyc);
                break;
            end
        end
        in_valid = 0; in_last = 0;
        model_done(i);
        e_ready = 0; e_busy = 1; e_xv = 1;
        r_x = x; r_fidx = fail_idx; r_fcnt = fail_cnt; r_lerr = len_err;
        if (start_in_done) start = 1;
        @(posedge clk); #1;
        start = 0; e_xv = 0; e_busy = 0;
    endtask

    initial begin
        cfg_we = 0; cfg_idx = 0; cfg_en = 0; cfg_lo = 0; cfg_hi = 0;
        start = 0; in_valid = 0; in_data = 0; in_last = 0;
        clear_model();
        chk_on = 1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Unconfigured block, all-ones data.
        fill(16'hFFFF, 149);
        run_frame(0, 0, 0, 0, 0, -1);
        chk("a_x", 32'(r_x), 32'd1);
        chk("a_fail_cnt", 32'(r_fcnt), 32'd0);
        chk("a_len_err", 32'(r_lerr), 32'd0);

        // Two failing checks; idx 7 written together with start.
        cfg_write(3, 1, 16'd10, 16'd20);
        fill(16'd0, 149); bd[3] = 16'd21; bd[7] = 16'd6;
        run_frame(0, 0, 0, 1, 0, -1);
        chk("b_x", 32'(r_x), 32'd0);
        chk("b_fail_idx", 32'(r_fidx), 32'd3);
        chk("b_fail_cnt", 32'(r_fcnt), 32'd2);

        // Inclusive bounds, back-to-back frames via start on DONE.
        fill(16'd0, 149); bd[3] = 16'd10; bd[7] = 16'd5;
        run_frame(0, 0, 1, 0, 0, -1);
        chk("c_x", 32'(r_x), 32'd1);
        fill(16'd0, 149); bd[3] = 16'd20;
        run_frame(0, 1, 0, 0, 0, -1);
        chk("d_x", 32'(r_x), 32'd1);

        // Short and overlong frames.
        fill(16'd0, 99); bd[3] = 16'd15;
        run_frame(0, 0, 0, 0, 0, -1);
        chk("e_x", 32'(r_x), 32'd0);
        chk("e_len_err", 32'(r_lerr), 32'd1);
        fill(16'd0, -1); bd[3] = 16'd15;
        run_frame(0, 0, 0, 0, 0, -1);
        chk("f_len_err", 32'(r_lerr), 32'd1);
        chk("f_x", 32'(r_x), 32'd0);

        // Out-of-range index dropped; writes during RUN ignored.
        cfg_write(200, 1, 16'd0, 16'd0);
        fill(16'd0, 149); bd[3] = 16'd15;
        run_frame(0, 0, 0, 0, 1, -1);
        chk("g_x", 32'(r_x), 32'd1);
        fill(16'd0, 149); bd[3] = 16'd5;
        run_frame(0, 0, 0, 0, 0, -1);
        chk("h_x", 32'(r_x), 32'd0);
        chk("h_fail_idx", 32'(r_fidx), 32'd3);

        // Same frame without and with input gaps.
        fill(16'd0, 149); bd[3] = 16'd12; bd[7] = 16'd9;
        run_frame(0, 0, 0, 0, 0, -1);
        chk("i_fail_idx", 32'(r_fidx), 32'd7);
        run_frame(30, 0, 0, 0, 0, -1);
        chk("j_fail_idx", 32'(r_fidx), 32'd7);
        chk("j_fail_cnt", 32'(r_fcnt), 32'd1);

        // Random tables and data, 30% gaps.
        repeat (6) begin
            int lp;
            repeat (10) cfg_write($urandom_range(0, 255), 1'($urandom), 16'($urandom_range(0, 30)),
                                  16'($urandom_range(0, 40)));
            lp = ($urandom_range(99) < 70) ? 149 : int'($urandom_range(0, 149));
            if ($urandom_range(99) < 15) lp = -1;
            fill(16'd0, lp);
            for (int k = 0; k < NV; k++) bd[k] = 16'($urandom_range(0, 40));
            run_frame(30, 0, 0, 0, 0, -1);
        end

        // Reset mid-frame, then a fresh frame on the cleared table.
        cfg_write(3, 1, 16'd10, 16'd20);
        fill(16'hFFFF, 149);
        run_frame(30, 0, 0, 0, 0, 50);
        fill(16'hFFFF, 149);
        run_frame(0, 0, 0, 0, 0, -1);
        chk("k_x", 32'(r_x), 32'd1);
        chk("k_fail_cnt", 32'(r_fcnt), 32'd0);

        repeat (2) @(posedge clk);
        chk_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/split_seq_checker.md
Name: split_seq_checker

Overview:
- Sequential, parametrised successor to the flat split-constraint blocks. Those blocks take every variable slice as a dedicated port and evaluate one fixed combinational predicate (constant true for trivial splits).
- This block receives the variables as a valid/ready stream, one per beat. It checks each against a per-variable range constraint held in a small configurable table. At the end of each frame it reports the ANDed verdict `x`, plus diagnostics.
- Sits between the stimulus/solver front end and the split-result collector.

Parameters:
- NUM_VARS, 150: variables per frame; must be >= 2.
- DATA_W, 16: stream and bound width; narrower variables are zero-extended by the sender.
- IDX_W, 8: index and counter width; 2**IDX_W >= NUM_VARS is required.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  constraint table write strobe.
- cfg_idx  in  IDX_W  table entry index.
- cfg_en  in  1  check enable for the entry; 0 means the entry always passes.
- cfg_lo  in  DATA_W  inclusive lower bound, unsigned.
- cfg_hi  in  DATA_W  inclusive upper bound, unsigned.
- start  in  1  begin a frame.
- in_valid  in  1  variable beat valid.
- in_ready  out  1  block accepts a beat.
- in_data  in  DATA_W  variable value.
- in_last  in  1  marks the final beat of the frame.
- busy  out  1  high in RUN and DONE.
- x_valid  out  1  one-cycle pulse: verdict available.
- x  out  1  frame verdict; 1 means all enabled checks passed and the length was correct.
- fail_idx  out  IDX_W  index of the first failing variable.
- fail_cnt  out  IDX_W  number of failing variables, saturating.
- len_err  out  1  frame length mismatch.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: in_ready=0, busy=0, x_valid=0, x=1, fail_idx=0, fail_cnt=0, len_err=0.
  - Every table entry is cleared to en=0, lo=0, hi=0. An unconfigured block therefore yields x=1, matching the trivial-split generation.
  - A reset mid-frame aborts the frame; no x_valid pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=0.
  - cfg_we with cfg_idx < NUM_VARS writes the entry at the clock edge. An out-of-range cfg_idx is dropped.
  - start=1 moves to RUN next cycle and clears beat counter cnt, acc=1, fail_cnt, fail_idx and len_err. x keeps its previous value until DONE.
  - If cfg_we and start arrive together, the write takes effect before the frame starts.
- RUN:
  - in_ready=1; a beat is accepted when in_valid & in_ready.
  - Check for beat cnt: pass = !en[cnt] | (lo[cnt] <= in_data && in_data <= hi[cnt]), all unsigned. lo > hi with en=1 never passes.
  - On a failing beat: acc cleared. If this is the first failure, fail_idx=cnt. fail_cnt increments, saturating at 2**IDX_W-1.
  - Frame ends on the accepted beat where in_last=1 or cnt==NUM_VARS-1, whichever comes first.
  - len_err=1 when in_last=1 with cnt != NUM_VARS-1, or when cnt==NUM_VARS-1 with in_last=0. Extra beats after that are not accepted in this frame.
  - On the final beat: go to DONE; cnt wraps to 0.
  - start, cfg_we are ignored in RUN; config writes are never applied mid-frame.
- DONE (exactly one cycle):
  - x_valid=1, x = acc & !len_err.
  - in_ready=0.
  - Then IDLE.
- Latency: x_valid is asserted on the cycle after the final accepted beat.
- Output holding: x, fail_idx, fail_cnt and len_err hold until the next start.
- Back-to-back frames: start may be asserted on the DONE cycle; it is registered and acted on in the following IDLE cycle.
- in_valid gaps: allowed in RUN with no timeout. The counter advances only on a handshake.

Test Plan:
- Reset, no config, start, 150 beats of 0xFFFF with in_last on beat 149 -> x_valid one cycle after beat 149, x=1, fail_cnt=0, len_err=0.
- Config idx 3 en=1 lo=10 hi=20 and idx 7 en=1 lo=0 hi=5; stream beat3=21, beat7=6, others 0 -> x=0, fail_idx=3, fail_cnt=2. Boundary values beat3=10 and beat3=20 must pass.
- Stream with in_last on beat 99 -> frame ends at beat 99, x=0, len_err=1. A 150-beat frame with in_last=0 on beat 149 -> len_err=1, x=0.
- cfg_we during RUN to idx 3 with lo=100 -> ignored; current and next frame still use lo=10. cfg_idx=200 in IDLE -> dropped.
- Random in_valid gaps at 30% duty -> result identical to a gapless frame; in_ready=0 in IDLE and DONE.
- rst_n pulsed low at beat 50 -> outputs immediately at reset values, table cleared, no x_valid. A fresh frame afterwards gives x=1.
